// File: rtl/vxe_fetch2w.sv
`default_nettype none
// ============================================================================
// Module      : vxe_fetch2w
// Description : Word-granular fetch engine over a 64-bit (doubleword) memory
//               port. Issues ordered reads and packs responses into a
//               2-word-wide FIFO with per-word write masks.
// Revision    : 1.0  initial release
// ============================================================================
module vxe_fetch2w #(
    parameter int AW     = 32,
    parameter int CW     = 16,
    parameter int MAXOUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_vld,
    output logic          cmd_rdy,
    input  logic [AW-1:0] cmd_addr,
    input  logic [CW-1:0] cmd_len,
    output logic          rq_vld,
    input  logic          rq_rdy,
    output logic [AW-2:0] rq_addr,
    input  logic          rs_vld,
    output logic          rs_rdy,
    input  logic [63:0]   rs_data,
    output logic [63:0]   fifo_data,
    output logic [1:0]    fifo_wr,
    input  logic          fifo_in_rdy,
    output logic          busy,
    output logic          done
);

    localparam int c_OW = $clog2(MAXOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_addr;
    logic [CW-1:0]   r_beats;
    logic [CW-1:0]   r_issued;
    logic [CW-1:0]   r_rcvd;
    logic            r_last_odd;
    logic [c_OW-1:0] r_outst;

    logic            w_accept;
    logic            w_rq_hs;
    logic            w_rs_hs;
    logic            w_first;
    logic            w_last;
    logic [CW-1:0]   w_beats;

    // (addr[0] + len + 1) >> 1 rewritten so no carry bit is needed:
    // floor(len/2) plus one more beat when either end is odd.
    assign w_beats = {1'b0, cmd_len[CW-1:1]} + CW'(cmd_len[0] | cmd_addr[0]);

    assign w_accept = cmd_vld && cmd_rdy;
    assign w_rq_hs  = rq_vld && rq_rdy;
    assign w_rs_hs  = rs_vld && rs_rdy;
    assign w_first  = (r_rcvd == '0);
    assign w_last   = (r_rcvd == r_beats - CW'(1));

    always_comb begin
        w_state_nxt = r_state;
        cmd_rdy     = 1'b0;
        rq_vld      = 1'b0;
        rs_rdy      = 1'b0;
        fifo_wr     = 2'b00;
        busy        = 1'b0;
        done        = 1'b0;
        rq_addr     = r_addr[AW-1:1] + (AW-1)'(r_issued);
        fifo_data   = rs_data;

        case (r_state)
            S_IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_vld) begin
                    w_state_nxt = (cmd_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                rq_vld = (r_issued != r_beats) && (r_outst < c_OW'(MAXOUT));
                rs_rdy = fifo_in_rdy;
                if (rs_vld && fifo_in_rdy) begin
                    // Partial words at either end of the range are masked off.
                    fifo_wr = {~(w_last && r_last_odd), ~(w_first && r_addr[0])};
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_beats    <= '0;
            r_issued   <= '0;
            r_rcvd     <= '0;
            r_last_odd <= 1'b0;
            r_outst    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr     <= cmd_addr;
                r_beats    <= w_beats;
                r_last_odd <= cmd_addr[0] ^ cmd_len[0];
                r_issued   <= '0;
                r_rcvd     <= '0;
                r_outst    <= '0;
            end else begin
                if (w_rq_hs) begin
                    r_issued <= r_issued + CW'(1);
                end
                if (w_rs_hs) begin
                    r_rcvd <= r_rcvd + CW'(1);
                end
                if (w_rq_hs && !w_rs_hs) begin
                    r_outst <= r_outst + c_OW'(1);
                end else if (!w_rq_hs && w_rs_hs) begin
                    r_outst <= r_outst - c_OW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vxe_fetch2w.sv
`default_nettype none
// ============================================================================
// Module      : tb_vxe_fetch2w
// Description : Self-checking bench for vxe_fetch2w (vectors + random model).
// Revision    : 1.0  initial release
// ============================================================================
module tb_vxe_fetch2w;

    localparam int AW     = 32;
    localparam int CW     = 16;
    localparam int MAXOUT = 4;

    logic          clk;
    logic          rst;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [AW-1:0] cmd_addr;
    logic [CW-1:0] cmd_len;
    logic          rq_vld;
    logic          rq_rdy;
    logic [AW-2:0] rq_addr;
    logic          rs_vld;
    logic          rs_rdy;
    logic [63:0]   rs_data;
    logic [63:0]   fifo_data;
    logic [1:0]    fifo_wr;
    logic          fifo_in_rdy;
    logic          busy;
    logic          done;

    vxe_fetch2w #(.AW(AW), .CW(CW), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rq_vld(rq_vld), .rq_rdy(rq_rdy), .rq_addr(rq_addr),
        .rs_vld(rs_vld), .rs_rdy(rs_rdy), .rs_data(rs_data),
        .fifo_data(fifo_data), .fifo_wr(fifo_wr), .fifo_in_rdy(fifo_in_rdy),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs (percent probabilities) and model state.
    int  p_rq, p_rs, p_fifo;
    bit  fifo_toggle, rs_hold0, want_cmd;
    int  phase;      // 0 idle, 1 run, 2 done
    int  m_beats, m_got, ndone;
    logic [31:0] c_addr;
    logic [15:0] c_len;
    logic [30:0] pend[$];
    logic [30:0] reqs[$];
    logic [31:0] words[$];
    logic [1:0]  masks[$];

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        int          nreq;
        logic [30:0] first_dw;
        logic [1:0]  m_first;
        logic [1:0]  m_last;
        int          nwr;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [31:0] wval(input logic [31:0] w);
        return w * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic [63:0] dwval(input logic [30:0] d);
        return {wval({d, 1'b1}), wval({d, 1'b0})};
    endfunction

    // Doublewords spanned by words [a, a+len-1], computed without wrap.
    function automatic int beats_of(input logic [31:0] a, input logic [15:0] l);
        longint unsigned la, first, last;
        if (l == 0) return 0;
        la    = {32'd0, a};
        first = la >> 1;
        last  = (la + l - 1) >> 1;
        return int'(last - first + 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit do_rst);
        bit acc, rqh, rsh;
        @(negedge clk);
        rst     = do_rst;
        cmd_vld = want_cmd;
        rq_rdy  = ($urandom_range(99) < p_rq);
        if (fifo_toggle) fifo_in_rdy = ~fifo_in_rdy;
        else             fifo_in_rdy = ($urandom_range(99) < p_fifo);
        rs_vld  = (pend.size() > 0) && !rs_hold0 && ($urandom_range(99) < p_rs);
        rs_data = rs_vld ? dwval(pend[0]) : {$urandom, $urandom};
        #1;
        if (do_rst) begin
            phase = 0;
            return;
        end
        chk("cmd_rdy", cmd_rdy, phase == 0);
        chk("busy", busy, phase != 0);
        chk("done", done, phase == 2);
        chk("rs_rdy", rs_rdy, (phase == 1) && fifo_in_rdy);
        if (phase != 1) chk("rq_vld_not_run", rq_vld, 0);
        acc = cmd_vld && cmd_rdy;
        rqh = rq_vld && rq_rdy;
        rsh = rs_vld && rs_rdy;
        if (!rsh) chk("fifo_wr_no_hs", fifo_wr, 0);
        if (rqh) begin
            chk("outstanding_limit", pend.size() < MAXOUT, 1);
            chk("over_issue", reqs.size() < m_beats, 1);
            pend.push_back(rq_addr);
            reqs.push_back(rq_addr);
        end
        if (rsh) begin
            chk("fifo_data", fifo_data, rs_data);
            if (fifo_wr[0]) words.push_back(fifo_data[31:0]);
            if (fifo_wr[1]) words.push_back(fifo_data[63:32]);
            masks.push_back(fifo_wr);
            m_got++;
            void'(pend.pop_front());
        end
        if (done) ndone++;
        case (phase)
            0: if (acc) begin
                want_cmd = 1'b0;
                m_beats  = beats_of(cmd_addr, cmd_len);
                phase    = (cmd_len == 0) ? 2 : 1;
            end
            1: if (rsh && m_got == m_beats) phase = 2;
            default: phase = 0;
        endcase
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [15:0] l);
        reqs.delete(); words.delete(); masks.delete();
        ndone = 0; m_got = 0; m_beats = 0;
        c_addr = a; c_len = l;
        cmd_addr = a; cmd_len = l;
        want_cmd = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            cycle(0);
            n++;
        end while ((want_cmd || phase != 0) && n < budget);
        chk("cmd_timeout", (want_cmd || phase != 0), 0);
    endtask

    task automatic end_checks(input string tag);
        int nb, bad;
        nb = beats_of(c_addr, c_len);
        chk({tag, "_nreq"}, reqs.size(), nb);
        bad = 0;
        foreach (reqs[k]) if (reqs[k] !== 31'(c_addr[31:1] + 31'(k))) bad++;
        chk({tag, "_req_addr_errs"}, bad, 0);
        chk({tag, "_nwords"}, words.size(), c_len);
        bad = 0;
        foreach (words[i]) if (words[i] !== wval(c_addr + 32'(i))) bad++;
        chk({tag, "_word_errs"}, bad, 0);
        chk({tag, "_ndone"}, ndone, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; cmd_vld = 1'b0; cmd_addr = '0; cmd_len = '0;
        rq_rdy = 1'b0; rs_vld = 1'b0; rs_data = '0; fifo_in_rdy = 1'b0;
        p_rq = 100; p_rs = 100; p_fifo = 100;
        fifo_toggle = 1'b0; rs_hold0 = 1'b0; want_cmd = 1'b0;
        phase = 0; m_beats = 0; m_got = 0; ndone = 0;

        cycle(1);
        cycle(1);
        cycle(0);
        chk("reset_rq_vld", rq_vld, 0);
        chk("reset_fifo_wr", fifo_wr, 0);
        chk("reset_cmd_rdy", cmd_rdy, 1);

        // addr, len, requests, first dw, first mask, last mask, writes
        vecs[0] = '{32'h0000_0100, 16'd8, 4, 31'h80, 2'b11, 2'b11, 4};
        vecs[1] = '{32'h0000_0101, 16'd4, 3, 31'h80, 2'b10, 2'b01, 3};
        vecs[2] = '{32'h0000_0101, 16'd1, 1, 31'h80, 2'b10, 2'b10, 1};
        vecs[3] = '{32'h0000_0100, 16'd1, 1, 31'h80, 2'b01, 2'b01, 1};
        vecs[4] = '{32'h0000_0100, 16'd0, 0, 31'h0,  2'b00, 2'b00, 0};
        vecs[5] = '{32'h0000_00FF, 16'd2, 2, 31'h7F, 2'b10, 2'b01, 2};
        vecs[6] = '{32'hFFFF_FFFF, 16'd3, 2, 31'h7FFF_FFFF, 2'b10, 2'b11, 2};
        for (int i = 0; i < 7; i++) begin
            start_cmd(vecs[i].addr, vecs[i].len);
            wait_idle(200);
            end_checks("vec");
            chk("vec_nreq_tbl", reqs.size(), vecs[i].nreq);
            chk("vec_nwr_tbl", masks.size(), vecs[i].nwr);
            if (reqs.size() > 0) chk("vec_first_dw", reqs[0], vecs[i].first_dw);
            if (masks.size() > 0) begin
                chk("vec_mask_first", masks[0], vecs[i].m_first);
                chk("vec_mask_last", masks[masks.size()-1], vecs[i].m_last);
            end
        end

        // Responses withheld: issue must stop at MAXOUT, then resume.
        rs_hold0 = 1'b1;
        start_cmd(32'h0000_0200, 16'd32);
        repeat (20) cycle(0);
        chk("stall_nreq", reqs.size(), MAXOUT);
        chk("stall_rq_vld", rq_vld, 0);
        rs_hold0 = 1'b0;
        wait_idle(500);
        end_checks("stall");

        // FIFO ready toggling every cycle.
        fifo_toggle = 1'b1;
        start_cmd(32'h0000_0400, 16'd16);
        wait_idle(500);
        end_checks("toggle");
        chk("toggle_nwr", masks.size(), 8);
        fifo_toggle = 1'b0;

        // Reset after two of four responses.
        start_cmd(32'h0000_0300, 16'd8);
        n = 0;
        while (masks.size() < 2 && n < 100) begin
            cycle(0);
            n++;
        end
        chk("rst_progress", masks.size(), 2);
        cycle(1);
        cycle(0);
        chk("rst_rq_vld", rq_vld, 0);
        chk("rst_rs_rdy", rs_rdy, 0);
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_busy", busy, 0);
        repeat (4) cycle(0);
        chk("rst_no_done", ndone, 0);
        pend.delete();
        start_cmd(32'h0000_0101, 16'd4);
        wait_idle(200);
        end_checks("post_rst");

        // Randomized commands and handshake timing.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [15:0] l;
            a = $urandom;
            if ($urandom_range(3) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(15));
            l = 16'($urandom_range(24));
            p_rq   = $urandom_range(30, 100);
            p_rs   = $urandom_range(30, 100);
            p_fifo = $urandom_range(30, 100);
            start_cmd(a, l);
            wait_idle(2000);
            end_checks("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
